// File: rtl/pftx_pkg.sv
// Shared types and constants for the parity frame transmitter.
package pftx_pkg;

  localparam int unsigned DATA_BITS  = 9;
  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned IDX_W      = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } pftx_state_e;

  typedef struct packed {
    logic       par;
    logic [7:0] data;
  } pftx_word_t;

  function automatic logic word_parity(input pftx_word_t w);
    return ^w;
  endfunction

endpackage

// File: rtl/pftx_baud_cnt.sv
// Bit-period counter; tick is high in the cycle before the last cycle of each bit,
// so the frame FSM can register both its bit advance and the done pulse.
module pftx_baud_cnt
  import pftx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == CNT_PRE);

endmodule

// File: rtl/parity_frame_tx.sv
// Serialises a 9-bit parity-appended word as start + 9 bits LSB first + stop.
// Optional parity cross-check enabled by macro PFTX_PARITY_CHECK_EN.
module parity_frame_tx
  import pftx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 par_odd,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic                 par_err
);

  pftx_state_e          r_state, w_nx_state;
  logic [DATA_BITS-1:0] r_shift, w_nx_shift;
  logic [IDX_W-1:0]     r_idx, w_nx_idx;
  logic                 r_tx, w_nx_tx;
  logic                 r_busy, w_nx_busy;
  logic                 r_done, w_nx_done;
  logic                 r_in_ready, w_nx_in_ready;
  logic                 r_bit_end, w_nx_bit_end;
  logic                 w_tick;
  logic                 w_clear;
  logic                 w_accept;

  assign w_clear  = (r_state == S_IDLE);
  assign w_accept = in_valid & r_in_ready;

  pftx_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_idx      <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_in_ready <= 1'b0;
      r_bit_end  <= 1'b0;
    end else begin
      r_state    <= w_nx_state;
      r_shift    <= w_nx_shift;
      r_idx      <= w_nx_idx;
      r_tx       <= w_nx_tx;
      r_busy     <= w_nx_busy;
      r_done     <= w_nx_done;
      r_in_ready <= w_nx_in_ready;
      r_bit_end  <= w_nx_bit_end;
    end
  end

  // Next state; r_bit_end marks the last cycle of the current bit
  always_comb begin
    w_nx_state   = r_state;
    w_nx_shift   = r_shift;
    w_nx_idx     = r_idx;
    w_nx_tx      = r_tx;
    w_nx_done    = 1'b0;
    w_nx_bit_end = w_tick & (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        w_nx_tx = 1'b1;
        if (w_accept) begin
          w_nx_state   = S_START;
          w_nx_shift   = in_data;
          w_nx_idx     = '0;
          w_nx_tx      = 1'b0;
          w_nx_bit_end = 1'b0;
        end
      end
      S_START: begin
        if (r_bit_end) begin
          w_nx_state = S_DATA;
          w_nx_tx    = r_shift[0];
        end
      end
      S_DATA: begin
        if (r_bit_end) begin
          if (r_idx == IDX_W'(DATA_BITS - 1)) begin
            w_nx_state = S_STOP;
            w_nx_tx    = 1'b1;
          end else begin
            w_nx_idx   = r_idx + IDX_W'(1);
            w_nx_shift = r_shift >> 1;
            w_nx_tx    = r_shift[1];
          end
        end
      end
      S_STOP: begin
        w_nx_done = w_tick;
        if (r_bit_end) begin
          w_nx_state = S_IDLE;
          w_nx_tx    = 1'b1;
        end
      end
      default: w_nx_state = S_IDLE;
    endcase
    w_nx_busy     = (w_nx_state != S_IDLE);
    w_nx_in_ready = (w_nx_state == S_IDLE);
  end

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign done     = r_done;
  assign in_ready = r_in_ready;

`ifdef PFTX_PARITY_CHECK_EN
  logic r_par_err;

  // Flag a word whose appended parity disagrees with the declared sense
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= w_accept & (word_parity(pftx_word_t'(in_data)) != par_odd);
    end
  end

  assign par_err = r_par_err;
`else
  logic w_unused_par_odd;
  assign w_unused_par_odd = par_odd;
  assign par_err          = 1'b0;
`endif

endmodule

// File: doc/parity_frame_tx.md
PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset synchronous and active-low.
REQ-004 SHALL have port in_data  input  9  parity-appended word from the parity generator: bit 8 = parity, bits 7:0 = data.
REQ-005 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port par_odd  input  1  parity sense of in_data (1 = odd, 0 = even); used only under REQ-026.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  a frame is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-011 SHALL have port par_err  output  1  one-cycle parity mismatch pulse (REQ-026).

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-013 SHALL drive in_ready = 1 only in IDLE and not in reset.
REQ-014 SHALL accept a word on a rising edge where in_valid & in_ready; latch in_data into a 9-bit shift register; enter START.
REQ-015 SHALL ignore in_valid while not in IDLE; in_data changes there have no effect.
REQ-016 SHALL emit the frame: start bit 0, in_data[0] through in_data[8] LSB first, stop bit 1; 11 bits total.
REQ-017 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles; first start-bit cycle is the cycle after acceptance.
REQ-018 SHALL leave DATA after the 9th bit, using a 4-bit index counting 0..8.
REQ-019 SHALL, on the last stop-bit cycle, pulse done for that one cycle and return to IDLE on the next edge.
REQ-020 SHALL yield a minimum accept-to-accept spacing of 11*CLKS_PER_BIT + 1 cycles (one IDLE cycle between frames).
REQ-021 SHALL drive busy = 1 in START, DATA and STOP, and 0 in IDLE.
REQ-022 SHALL drive tx, busy, done and par_err from registers (no combinational path from inputs).
REQ-023 SHALL size the baud counter to ceil(log2(CLKS_PER_BIT)) bits and reset it to 0 at every bit boundary; no wrap beyond CLKS_PER_BIT-1.

Reset
REQ-024 SHALL, while rst_n = 0 at a rising edge, force state IDLE, tx = 1, busy = 0, done = 0, par_err = 0, and clear the counters and shift register; in_ready = 0 during reset.
REQ-025 SHALL abort any frame in progress on reset mid-frame, with tx high from the next edge and no done pulse.

Configuration
REQ-026 SHALL, with macro PFTX_PARITY_CHECK_EN defined, compute XOR of in_data[8:0] on acceptance and pulse par_err in the cycle after acceptance when that XOR != par_odd; the frame is still transmitted unchanged.
REQ-027 SHALL, without PFTX_PARITY_CHECK_EN, tie par_err to 0, leave par_odd unused, and contain no checking logic.

Structure
REQ-028 SHALL take the FSM state encoding, FRAME_BITS = 11 and DATA_BITS = 9 from shared package pftx_pkg.
REQ-029 SHALL put the baud tick counter in one sub-module, pftx_baud_cnt (parameter CLKS_PER_BIT; inputs clk, rst_n, clear; output tick).

Verification
REQ-030 SHALL cover: CLKS_PER_BIT=4, in_data=9'h055 accepted -> tx sequence 0,1,0,1,0,1,0,1,0,0,1, each held 4 cycles; done pulses at cycle 44 after acceptance.
REQ-031 SHALL cover: in_valid held high with 9'h1FF then 9'h000 -> second acceptance exactly 45 cycles after the first (CLKS_PER_BIT=4); in_ready low throughout the first frame.
REQ-032 SHALL cover: rst_n low for 1 cycle during the 5th data bit -> tx=1, busy=0 next edge, no done pulse, in_ready=1 the cycle after rst_n returns high.
REQ-033 SHALL cover: with PFTX_PARITY_CHECK_EN, in_data=9'h155, par_odd=0 -> par_err=1 for one cycle after acceptance; par_odd=1 -> par_err stays 0.
REQ-034 SHALL cover: in_data changed while busy -> transmitted bits match the word latched at acceptance.
REQ-035 SHALL cover: CLKS_PER_BIT=2 boundary -> full frame of 22 cycles, done at cycle 22.
